ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter SIZE, default 4096: RAM depth in 32-bit words; header counts above SIZE are rejected.
REQ-002 Parameter AW, default 12: RAM word-address width; SIZE SHALL be no greater than 2**AW.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  single-cycle pulse that begins (or restarts) a load.
REQ-006 byte_valid_i  input  1  upstream byte stream valid.
REQ-007 byte_data_i  input  8  upstream byte payload.
REQ-008 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 ram_addr_o  output  AW  RAM word address.
REQ-010 ram_valid_o  output  1  RAM port access strobe.
REQ-011 ram_we_o  output  4  RAM byte write enables.
REQ-012 ram_data_o  output  32  RAM write data.
REQ-013 busy_o  output  1  a load is in progress.
REQ-014 done_o  output  1  sticky: the last load completed successfully.
REQ-015 err_o  output  1  sticky: the last load was rejected (header count above SIZE).
REQ-016 cpu_hold_o  output  1  holds the core off the RAM; high whenever busy_o is high.

Function
REQ-017 A byte SHALL transfer only in a cycle where byte_valid_i and byte_ready_o are both 1; byte_ready_o SHALL NOT depend combinationally on byte_valid_i.
REQ-018 The FSM SHALL have the states IDLE, HDR, DATA, WRITE, DONE and ERR.
REQ-019 IDLE/DONE/ERR + start_i SHALL go to HDR and clear the byte counter, word index, done_o and err_o.
REQ-020 In HDR, byte_ready_o=1; 4 accepted bytes SHALL form the 32-bit word count N, little-endian (first byte = N[7:0]).
REQ-021 After the 4th header byte: N=0 SHALL go to DONE; N>SIZE SHALL go to ERR; otherwise the FSM SHALL go to DATA.
REQ-022 In DATA, byte_ready_o=1; 4 accepted bytes SHALL assemble one little-endian word, then the FSM SHALL go to WRITE.
REQ-023 WRITE SHALL last exactly one cycle with ram_valid_o=1, ram_we_o=4'hF, ram_addr_o=word index, ram_data_o=assembled word and byte_ready_o=0.
REQ-024 After WRITE, the word index SHALL increment; index==N SHALL go to DONE, otherwise the FSM SHALL return to DATA.
REQ-025 Write latency: ram_valid_o SHALL assert the cycle after the 4th data byte is accepted.
REQ-026 Outside WRITE, ram_valid_o=0 and ram_we_o=0; ram_addr_o/ram_data_o SHALL hold their last values.
REQ-027 The word index SHALL be AW+1 bits wide so that index==SIZE compares without wrap-around.
REQ-028 busy_o=1 exactly in HDR, DATA and WRITE.
REQ-029 done_o=1 exactly in DONE; err_o=1 exactly in ERR; both SHALL hold until the next start_i.
REQ-030 start_i in HDR, DATA or WRITE SHALL abort the current load and restart it in HDR on the next cycle; a partially assembled word SHALL be discarded, and a start_i coinciding with WRITE SHALL still complete that cycle's write.
REQ-031 A byte accepted in the same cycle as start_i SHALL be dropped.
REQ-032 Stalls SHALL be unbounded: byte_valid_i=0 for any number of cycles SHALL leave all state unchanged.

Reset
REQ-033 Asserting rst_ni low SHALL immediately force state=IDLE, all counters to 0, ram_addr_o=0, ram_data_o=0 and all other outputs to 0, including cpu_hold_o.
REQ-034 Reset asserted mid-load SHALL abandon the load; RAM writes already issued are not undone and no further write SHALL occur.
REQ-035 After rst_ni deasserts, the block SHALL remain in IDLE until start_i.

Verification
REQ-036 Basic: start; bytes 02 00 00 00, 78 56 34 12, EF BE AD DE -> writes addr0=0x12345678 then addr1=0xDEADBEEF with we=F; done_o=1; busy_o and cpu_hold_o return to 0.
REQ-037 Zero length: header 00 00 00 00 -> no ram_valid_o pulse; done_o=1 the cycle after the 4th byte.
REQ-038 Oversize: SIZE=4096, header 01 10 00 00 (N=4097) -> err_o=1, no write, byte_ready_o=0.
REQ-039 Backpressure/stall: random byte_valid_i gaps with N=3 -> exactly 3 writes at addresses 0,1,2 with correct data; byte_ready_o=0 in every WRITE cycle.
REQ-040 Abort: start_i after 2 data bytes of word 1 -> no write of the partial word; a fresh header N=1, data AA BB CC DD -> addr0=0xDDCCBBAA; done_o=1.
REQ-041 Reset mid-DATA: rst_ni low for 1 cycle -> all outputs 0 immediately; no ram_valid_o until a new start_i.

Source files
------------

// File: rtl/ram_loader.sv
// Byte-stream RAM loader: a 4-byte little-endian word count N followed by
// N little-endian data words, written to consecutive RAM addresses from 0.
module ram_loader #(
  parameter int SIZE = 4096,
  parameter int AW   = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_valid_o,
  output logic [3:0]    ram_we_o,
  output logic [31:0]   ram_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          cpu_hold_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam logic [31:0] SIZE_W  = 32'(SIZE);
  localparam logic [AW:0] IDX_ONE = (AW+1)'(1);

  state_e      state;
  logic [1:0]  byte_cnt;
  logic [31:0] shift_q;
  logic [AW:0] n_words;
  logic [AW:0] word_idx;
  logic [AW:0] idx_next;
  logic [31:0] next_word;
  logic        byte_fire;

  // Bytes arrive LSB first, so each new byte enters at the top and the
  // assembled word slides down; after four bytes the first sits in [7:0].
  assign next_word = {byte_data_i, shift_q[31:8]};
  assign idx_next  = word_idx + IDX_ONE;

  // Status outputs are pure decodes of the state register, so byte_ready_o
  // never depends on byte_valid_i.
  assign byte_ready_o = (state == HDR) || (state == DATA);
  assign busy_o       = (state == HDR) || (state == DATA) || (state == WRITE);
  assign cpu_hold_o   = busy_o;
  assign done_o       = (state == DONE);
  assign err_o        = (state == ERR);
  assign byte_fire    = byte_valid_i && byte_ready_o;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      byte_cnt    <= 2'd0;
      shift_q     <= 32'd0;
      n_words     <= '0;
      word_idx    <= '0;
      ram_addr_o  <= '0;
      ram_data_o  <= 32'd0;
      ram_valid_o <= 1'b0;
      ram_we_o    <= 4'h0;
    end else begin
      ram_valid_o <= 1'b0;
      ram_we_o    <= 4'h0;
      if (start_i) begin
        // Start wins over any byte handshake in the same cycle; a write
        // already presented this cycle (WRITE) still completes on the port.
        state    <= HDR;
        byte_cnt <= 2'd0;
        shift_q  <= 32'd0;
        word_idx <= '0;
      end else begin
        case (state)
          HDR: begin
            if (byte_fire) begin
              shift_q  <= next_word;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                if (next_word == 32'd0) begin
                  state <= DONE;
                end else if (next_word > SIZE_W) begin
                  state <= ERR;
                end else begin
                  n_words <= next_word[AW:0];
                  state   <= DATA;
                end
              end
            end
          end
          DATA: begin
            if (byte_fire) begin
              shift_q  <= next_word;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                ram_valid_o <= 1'b1;
                ram_we_o    <= 4'hF;
                ram_addr_o  <= word_idx[AW-1:0];
                ram_data_o  <= next_word;
                state       <= WRITE;
              end
            end
          end
          WRITE: begin
            word_idx <= idx_next;
            state    <= (idx_next == n_words) ? DONE : DATA;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: header table plus hand-written sequences
// for streaming, stalls, abort, start/byte collisions and mid-load reset.
module tb_ram_loader;

  localparam int SIZE = 4096;
  localparam int AW   = 12;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          byte_valid_i = 1'b0;
  logic [7:0]    byte_data_i = 8'h00;
  logic          byte_ready_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_valid_o;
  logic [3:0]    ram_we_o;
  logic [31:0]   ram_data_o;
  logic          busy_o, done_o, err_o, cpu_hold_o;

  int checks = 0;
  int errors = 0;

  // Write log filled by the port monitor
  logic [AW-1:0] wr_addr [64];
  logic [31:0]   wr_data [64];
  int            wr_n = 0;

  ram_loader #(.SIZE(SIZE), .AW(AW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .byte_valid_i(byte_valid_i),
    .byte_data_i (byte_data_i),
    .byte_ready_o(byte_ready_o),
    .ram_addr_o  (ram_addr_o),
    .ram_valid_o (ram_valid_o),
    .ram_we_o    (ram_we_o),
    .ram_data_o  (ram_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cpu_hold_o  (cpu_hold_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && ram_valid_o === 1'b1) begin
      check("write_we", {28'd0, ram_we_o}, 32'hF);
      check("write_ready_low", {31'd0, byte_ready_o}, 32'd0);
      if (wr_n < 64) begin
        wr_addr[wr_n] = ram_addr_o;
        wr_data[wr_n] = ram_data_o;
      end
      wr_n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) @(negedge clk_i);
    @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (byte_ready_o !== 1'b1 && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted in 50 cycles", b);
    end
    @(posedge clk_i);
    #1 byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  typedef struct {
    logic [31:0] n;
    logic        exp_done;
    logic        exp_err;
    logic        exp_busy;
  } hdr_vec_t;

  hdr_vec_t vecs [6];
  int base;

  initial begin
    vecs[0] = '{n: 32'd1,          exp_done: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[1] = '{n: 32'd4096,       exp_done: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[2] = '{n: 32'd0,          exp_done: 1'b1, exp_err: 1'b0, exp_busy: 1'b0};
    vecs[3] = '{n: 32'h0000_1001,  exp_done: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[4] = '{n: 32'h0001_0000,  exp_done: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[5] = '{n: 32'hFFFF_FFFF,  exp_done: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};

    // Reset state
    #3;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold_o}, 32'd0);
    check("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    check("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
    check("rst_ram", {ram_valid_o, ram_we_o, 7'd0, ram_addr_o, 8'd0}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    check("idle_after_rst", {29'd0, busy_o, done_o, err_o}, 32'd0);

    // Basic two-word load
    pulse_start();
    check("basic_hdr_busy", {30'd0, busy_o, cpu_hold_o}, 32'd3);
    send_word(32'd2, 0);
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 0);
    check("basic_latency", {31'd0, ram_valid_o}, 32'd1);
    repeat (2) @(negedge clk_i);
    check("basic_nwr", wr_n, 2);
    check("basic_a0", {20'd0, wr_addr[0]}, 32'd0);
    check("basic_d0", wr_data[0], 32'h1234_5678);
    check("basic_a1", {20'd0, wr_addr[1]}, 32'd1);
    check("basic_d1", wr_data[1], 32'hDEAD_BEEF);
    check("basic_status", {28'd0, busy_o, cpu_hold_o, done_o, err_o}, 32'h2);
    check("basic_hold_addr", {20'd0, ram_addr_o}, 32'd1);
    check("basic_hold_data", ram_data_o, 32'hDEAD_BEEF);

    // Header table: decision after the fourth header byte
    foreach (vecs[i]) begin
      base = wr_n;
      pulse_start();
      check("tbl_start_clears", {30'd0, done_o, err_o}, 32'd0);
      send_word(vecs[i].n, 0);
      check($sformatf("tbl%0d_done", i), {31'd0, done_o}, {31'd0, vecs[i].exp_done});
      check($sformatf("tbl%0d_err", i), {31'd0, err_o}, {31'd0, vecs[i].exp_err});
      check($sformatf("tbl%0d_busy", i), {30'd0, busy_o, cpu_hold_o},
            {30'd0, vecs[i].exp_busy, vecs[i].exp_busy});
      check($sformatf("tbl%0d_ready", i), {31'd0, byte_ready_o}, {31'd0, vecs[i].exp_busy});
      repeat (3) @(negedge clk_i);
      check($sformatf("tbl%0d_nowrite", i), wr_n - base, 0);
      check($sformatf("tbl%0d_sticky", i), {30'd0, done_o, err_o},
            {30'd0, vecs[i].exp_done, vecs[i].exp_err});
    end

    // Backpressure with random gaps and one long stall, N=3
    base = wr_n;
    pulse_start();
    send_word(32'd3, 3);
    send_word(32'hA1A2_A3A4, 3);
    send_byte(8'h01, 2);
    send_byte(8'h02, 0);
    repeat (20) @(negedge clk_i);
    check("stall_busy", {30'd0, busy_o, byte_ready_o}, 32'd3);
    check("stall_nwr", wr_n - base, 1);
    send_byte(8'h03, 1);
    send_byte(8'h04, 3);
    send_word(32'hCAFE_F00D, 3);
    repeat (2) @(negedge clk_i);
    check("bp_nwr", wr_n - base, 3);
    check("bp_a0", {20'd0, wr_addr[base]}, 32'd0);
    check("bp_d0", wr_data[base], 32'hA1A2_A3A4);
    check("bp_a1", {20'd0, wr_addr[base+1]}, 32'd1);
    check("bp_d1", wr_data[base+1], 32'h0403_0201);
    check("bp_a2", {20'd0, wr_addr[base+2]}, 32'd2);
    check("bp_d2", wr_data[base+2], 32'hCAFE_F00D);
    check("bp_done", {30'd0, done_o, busy_o}, 32'd2);

    // Abort after two data bytes of word 1
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h1111_1111, 0);
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    base = wr_n;
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'hDDCC_BBAA, 0);
    repeat (2) @(negedge clk_i);
    check("abort_nwr", wr_n - base, 1);
    check("abort_a", {20'd0, wr_addr[base]}, 32'd0);
    check("abort_d", wr_data[base], 32'hDDCC_BBAA);
    check("abort_done", {31'd0, done_o}, 32'd1);

    // Byte offered together with start in HDR is dropped; partial header discarded
    base = wr_n;
    pulse_start();
    send_byte(8'h07, 0);
    @(negedge clk_i);
    start_i = 1'b1;
    byte_valid_i = 1'b1;
    byte_data_i = 8'hFF;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    byte_valid_i = 1'b0;
    send_word(32'd1, 0);
    send_word(32'h4433_2211, 0);
    repeat (2) @(negedge clk_i);
    check("drop_nwr", wr_n - base, 1);
    check("drop_d", wr_data[base], 32'h4433_2211);
    check("drop_done", {31'd0, done_o}, 32'd1);

    // Start coinciding with WRITE still completes the write, then restarts
    base = wr_n;
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h5566_7788, 0);
    start_i = 1'b1;
    check("wstart_valid", {31'd0, ram_valid_o}, 32'd1);
    @(posedge clk_i);
    #1 start_i = 1'b0;
    check("wstart_hdr", {29'd0, byte_ready_o, busy_o, done_o}, 32'h6);
    check("wstart_nwr", wr_n - base, 1);
    check("wstart_d", wr_data[base], 32'h5566_7788);
    send_word(32'd1, 0);
    send_word(32'h9ABC_DEF0, 0);
    repeat (2) @(negedge clk_i);
    check("wstart_nwr2", wr_n - base, 2);
    check("wstart_a2", {20'd0, wr_addr[base+1]}, 32'd0);
    check("wstart_d2", wr_data[base+1], 32'h9ABC_DEF0);

    // Reset mid-DATA
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("mrst_status", {27'd0, busy_o, cpu_hold_o, done_o, err_o, byte_ready_o}, 32'd0);
    check("mrst_ram", {ram_valid_o, ram_we_o, 7'd0, ram_addr_o, 8'd0}, 32'd0);
    check("mrst_data", ram_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    base = wr_n;
    byte_valid_i = 1'b1;
    byte_data_i = 8'h30;
    repeat (8) @(negedge clk_i);
    byte_valid_i = 1'b0;
    check("mrst_nowrite", wr_n - base, 0);
    check("mrst_idle", {30'd0, busy_o, byte_ready_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
